// File: rtl/rv_ssc_bundle_sched.sv
// rtl/rv_ssc_bundle_sched.sv - issue-bundle scheduler queue (RV_SSC_3WIDE_EN enables 3-wide bundles)
`timescale 1ns/1ps

module rv_ssc_bundle_sched #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 48
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [1:0]      in_count,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_word0,
    input  logic [31:0]     in_word1,
    input  logic [31:0]     in_word2,
    input  logic [3:0]      in_flag0,
    input  logic [3:0]      in_flag1,
    input  logic [3:0]      in_flag2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_width,
    output logic [PC_W-1:0] out_pc0,
    output logic [31:0]     out_word0,
    output logic [31:0]     out_word1,
    output logic [31:0]     out_word2,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_bndl
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH - 3);

    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [PC_W-1:0] pc_d   [DEPTH];
    logic [31:0]     word_q [DEPTH];
    logic [31:0]     word_d [DEPTH];
    logic [3:0]      flag_q [DEPTH];
    logic [3:0]      flag_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [31:0]   perf_ops_q, perf_ops_d;
    logic [31:0]   perf_bndl_q, perf_bndl_d;

    logic [PW-1:0] h0, h1;
    logic          can_w2, can_w3;
    logic [1:0]    bndl_w;
    logic          push, pop;
    logic [31:0]   in_word [3];
    logic [3:0]    in_flag [3];

    // Conservative: raw field compare, so immediates that alias a register field also stall.
    function automatic logic hazard(input logic [31:0] early, input logic [31:0] late);
        logic [4:0] rd;
        rd = early[11:7];
        return (rd != 5'd0) &&
               ((late[19:15] == rd) || (late[24:20] == rd) || (late[11:7] == rd));
    endfunction

    assign h0 = rd_ptr_q;
    assign h1 = rd_ptr_q + PW'(1);

    assign can_w2 = (occ_q >= CW'(2)) && flag_q[h0][0] && flag_q[h1][2] &&
                    !hazard(word_q[h0], word_q[h1]);

`ifdef RV_SSC_3WIDE_EN
    logic [PW-1:0] h2;
    assign h2 = rd_ptr_q + PW'(2);
    assign can_w3 = (occ_q >= CW'(3)) && flag_q[h0][1] && flag_q[h1][2] && flag_q[h2][3] &&
                    !hazard(word_q[h0], word_q[h1]) &&
                    !hazard(word_q[h0], word_q[h2]) &&
                    !hazard(word_q[h1], word_q[h2]);
`else
    logic unused_flag_bits;
    assign can_w3 = 1'b0;
    always_comb begin
        unused_flag_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_flag_bits = unused_flag_bits ^ flag_q[i][1] ^ flag_q[i][3];
        end
    end
`endif

    always_comb begin
        bndl_w = 2'd1;
        if (occ_q == '0) begin
            bndl_w = 2'd0;
        end else if (can_w3) begin
            bndl_w = 2'd3;
        end else if (can_w2) begin
            bndl_w = 2'd2;
        end
    end

    assign in_ready  = (occ_q <= OCC_MAX);
    assign out_valid = (occ_q != '0);
    assign out_width = bndl_w;
    assign out_pc0   = out_valid ? pc_q[h0] : '0;
    assign out_word0 = out_valid ? word_q[h0] : NOP;
    assign out_word1 = (bndl_w >= 2'd2) ? word_q[h1] : NOP;
`ifdef RV_SSC_3WIDE_EN
    assign out_word2 = (bndl_w == 2'd3) ? word_q[h2] : NOP;
`else
    assign out_word2 = NOP;
`endif
    assign perf_ops  = perf_ops_q;
    assign perf_bndl = perf_bndl_q;

    assign in_word[0] = in_word0;
    assign in_word[1] = in_word1;
    assign in_word[2] = in_word2;
    assign in_flag[0] = in_flag0;
    assign in_flag[1] = in_flag1;
    assign in_flag[2] = in_flag2;

    assign push = in_ready && (in_count != 2'd0) && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        pc_d        = pc_q;
        word_d      = word_q;
        flag_d      = flag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        perf_ops_d  = perf_ops_q;
        perf_bndl_d = perf_bndl_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) < in_count) begin
                        pc_d[wr_ptr_q + PW'(i)]   = in_pc + PC_W'(4 * i);
                        word_d[wr_ptr_q + PW'(i)] = in_word[i];
                        flag_d[wr_ptr_q + PW'(i)] = in_flag[i];
                    end
                end
                wr_ptr_d = wr_ptr_q + PW'(in_count);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PW'(bndl_w);
                perf_ops_d  = perf_ops_q + 32'(bndl_w);
                perf_bndl_d = perf_bndl_q + 32'd1;
            end
            occ_d = occ_q + (push ? CW'(in_count) : '0) - (pop ? CW'(bndl_w) : '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= NOP;
                flag_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            perf_ops_q  <= '0;
            perf_bndl_q <= '0;
        end else begin
            pc_q        <= pc_d;
            word_q      <= word_d;
            flag_q      <= flag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            perf_ops_q  <= perf_ops_d;
            perf_bndl_q <= perf_bndl_d;
        end
    end

endmodule

// File: tb/tb_rv_ssc_bundle_sched.sv
// tb/tb_rv_ssc_bundle_sched.sv - scoreboard bench for rv_ssc_bundle_sched
`timescale 1ns/1ps

module tb_rv_ssc_bundle_sched;

    localparam int DEPTH = 8;
    localparam int PC_W  = 48;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clock, reset, flush;
    logic [1:0]      in_count;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_word0, in_word1, in_word2;
    logic [3:0]      in_flag0, in_flag1, in_flag2;
    logic            out_valid, out_ready;
    logic [1:0]      out_width;
    logic [PC_W-1:0] out_pc0;
    logic [31:0]     out_word0, out_word1, out_word2;
    logic [31:0]     perf_ops, perf_bndl;

    rv_ssc_bundle_sched #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_count(in_count), .in_ready(in_ready), .in_pc(in_pc),
        .in_word0(in_word0), .in_word1(in_word1), .in_word2(in_word2),
        .in_flag0(in_flag0), .in_flag1(in_flag1), .in_flag2(in_flag2),
        .out_valid(out_valid), .out_ready(out_ready), .out_width(out_width),
        .out_pc0(out_pc0), .out_word0(out_word0), .out_word1(out_word1),
        .out_word2(out_word2), .perf_ops(perf_ops), .perf_bndl(perf_bndl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [PC_W-1:0] pc; logic [31:0] word; logic [3:0] flag; } ent_t;
    typedef struct { int w; logic [PC_W-1:0] pc; logic [31:0] w0, w1, w2; } bndl_t;
    typedef struct { logic rdy; logic vld; } st_t;

    ent_t  mq[$];
    bndl_t expq[$];
    st_t   stq[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic [31:0] m_ops = 0;
    logic [31:0] m_bndl = 0;
    bit    done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit dep(input logic [31:0] e, input logic [31:0] l);
        return (e[11:7] != 0) && (l[19:15] == e[11:7] || l[24:20] == e[11:7] || l[11:7] == e[11:7]);
    endfunction

    function automatic int mwidth();
        int n = mq.size();
`ifdef RV_SSC_3WIDE_EN
        if (n >= 3 && mq[0].flag[1] && mq[1].flag[2] && mq[2].flag[3] &&
            !dep(mq[0].word, mq[1].word) && !dep(mq[0].word, mq[2].word) &&
            !dep(mq[1].word, mq[2].word))
            return 3;
`endif
        if (n >= 2 && mq[0].flag[0] && mq[1].flag[2] && !dep(mq[0].word, mq[1].word))
            return 2;
        return (n == 0) ? 0 : 1;
    endfunction

    function automatic logic [31:0] rword();
        return {7'($urandom), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                3'($urandom), 5'($urandom_range(0, 5)), 7'($urandom)};
    endfunction

    // One clock: drive inputs, advance the reference queue, record expectations.
    task automatic cyc(input int cnt, input logic [PC_W-1:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] fa, input logic [3:0] fb, input logic [3:0] fc,
                       input bit rdy, input bit fl);
        logic [31:0] ws [3];
        logic [3:0]  fs [3];
        bit acc;
        int w;
        bndl_t bd;
        ws[0] = a; ws[1] = b; ws[2] = c;
        fs[0] = fa; fs[1] = fb; fs[2] = fc;
        in_count = 2'(cnt); in_pc = pc;
        in_word0 = a; in_word1 = b; in_word2 = c;
        in_flag0 = fa; in_flag1 = fb; in_flag2 = fc;
        out_ready = rdy; flush = fl;
        stq.push_back('{rdy: (mq.size() <= DEPTH - 3), vld: (mq.size() != 0)});
        acc = (mq.size() <= DEPTH - 3) && (cnt != 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (rdy && mq.size() != 0) begin
                w = mwidth();
                bd.w  = w;
                bd.pc = mq[0].pc;
                bd.w0 = mq[0].word;
                bd.w1 = (w >= 2) ? mq[1].word : NOP;
                bd.w2 = (w >= 3) ? mq[2].word : NOP;
                expq.push_back(bd);
                m_ops  += 32'(w);
                m_bndl += 1;
                repeat (w) void'(mq.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < cnt; i++)
                    mq.push_back('{pc: pc + PC_W'(4 * i), word: ws[i], flag: fs[i]});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, NOP, NOP, NOP, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        in_count = 2'd3;
        #2 reset = 1'b0;
        mq.delete(); expq.delete(); stq.delete();
        m_ops = 0; m_bndl = 0;
        repeat (2) @(posedge clock);
        #1;
        in_count = 2'd0; out_ready = 1'b0; flush = 1'b0;
        reset = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_width", out_width, 0);
        chk("rst_out_word0", out_word0, NOP);
        chk("rst_perf_ops", perf_ops, 0);
        chk("rst_perf_bndl", perf_bndl, 0);
    endtask

    initial begin : monitor
        st_t   st;
        bndl_t bd;
        forever begin
            @(negedge clock);
            if (reset && !done) begin
                if (stq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL status_queue actual=empty required=entry at %0t", $time);
                end else begin
                    st = stq.pop_front();
                    chk("in_ready", in_ready, st.rdy);
                    chk("out_valid", out_valid, st.vld);
                end
                if (!out_valid) chk("idle_width", out_width, 0);
                if (out_valid && out_ready && !flush) begin
                    if (expq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL extra_bundle actual=width%0d required=none at %0t", out_width, $time);
                    end else begin
                        bd = expq.pop_front();
                        chk("out_width", out_width, bd.w);
                        chk("out_pc0", out_pc0, bd.pc);
                        chk("out_word0", out_word0, bd.w0);
                        chk("out_word1", out_word1, bd.w1);
                        chk("out_word2", out_word2, bd.w2);
                    end
                end else if (expq.size() != 0) begin
                    bd = expq.pop_front();
                    vectors++; miscompares++;
                    $display("FAIL missing_bundle actual=none required=width%0d at %0t", bd.w, $time);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] base_ops, base_bndl;
        logic [PC_W-1:0] pc;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0; in_count = 2'd0; in_pc = '0;
        in_word0 = NOP; in_word1 = NOP; in_word2 = NOP;
        in_flag0 = 4'h0; in_flag1 = 4'h0; in_flag2 = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        do_reset();

        // T2: three independent ADDIs
        cyc(3, 48'h1000, 32'h00100093, 32'h00200113, 32'h00300193, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        idle(4);
        chk("t2_perf_ops", perf_ops, 3);
`ifdef RV_SSC_3WIDE_EN
        chk("t2_perf_bndl", perf_bndl, 1);
`else
        chk("t2_perf_bndl", perf_bndl, 2);
`endif

        // T3: RAW on x1 splits the pair
        base_ops = m_ops; base_bndl = m_bndl;
        cyc(2, 48'h2000, 32'h00100093, 32'h00108113, NOP, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
        idle(4);
        chk("t3_perf_bndl", perf_bndl, base_bndl + 2);
        chk("t3_perf_ops", perf_ops, base_ops + 2);

        // T4: LW+ADDI pairs; BEQ without lane flags issues alone
        base_ops = m_ops; base_bndl = m_bndl;
        cyc(2, 48'h3000, 32'h00032283, 32'h00100093, NOP, 4'b0011, 4'hF, 4'h0, 1'b1, 1'b0);
        idle(3);
        chk("t4a_perf_bndl", perf_bndl, base_bndl + 1);
        chk("t4a_perf_ops", perf_ops, base_ops + 2);
        cyc(2, 48'h3100, 32'h00000063, 32'h00100093, NOP, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
        idle(4);
        chk("t4b_perf_bndl", perf_bndl, base_bndl + 3);
        chk("t4b_perf_ops", perf_ops, base_ops + 4);

        // T5: fill to DEPTH with the consumer stalled, then drain
        cyc(3, 48'h4000, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        cyc(2, 48'h400C, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        cyc(3, 48'h4014, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t5_full_in_ready", in_ready, 0);
        cyc(3, 48'h5000, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        idle(10);
        chk("t5_drained", out_valid, 0);
        chk("t5_perf_ops", perf_ops, m_ops);

        // T6: flush beats same-cycle push and pop
        cyc(2, 48'h6000, rword(), rword(), NOP, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
        base_ops = m_ops; base_bndl = m_bndl;
        cyc(3, 48'h7000, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
        chk("t6_empty", out_valid, 0);
        chk("t6_perf_ops", perf_ops, base_ops);
        chk("t6_perf_bndl", perf_bndl, base_bndl);

        pc = 48'h8000;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                cyc(3, pc, rword(), rword(), rword(), 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
                do_reset();
            end
            cyc(int'($urandom_range(0, 3)), pc, rword(), rword(), rword(),
                4'($urandom | $urandom), 4'($urandom | $urandom), 4'($urandom | $urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            pc = pc + 48'd12;
        end
        idle(8);
        chk("final_perf_ops", perf_ops, m_ops);
        chk("final_perf_bndl", perf_bndl, m_bndl);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
